// File: rtl/readback_buffer_pkg.sv
// Shared constants, injection FSM states and report-word helpers for the readback buffer.
// Pure declarations: no latency, no flow control.
package readback_buffer_pkg;

  localparam int RB_ADDR_W = 4;
  localparam int RB_DATA_W = 28;
  localparam int RB_WORD_W = 32;
  localparam logic [RB_ADDR_W-1:0] RB_REPORT_ADDR = 4'hF;

  typedef enum logic {
    ST_IDLE,
    ST_PENDING
  } inj_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Synthetic lost-word report: channel F, delta in the low 16 payload bits.
  function automatic logic [RB_WORD_W-1:0] report_word(input logic [15:0] delta);
    return {RB_REPORT_ADDR, {(RB_DATA_W-16){1'b0}}, delta};
  endfunction

endpackage

// File: rtl/readback_buffer_if.sv
// Readback word handshake bundle: arbiter-side strobe/ready and SPI-side valid/ready.
// Wires only: no latency; in_rdy and out_rdy carry the backpressure.
interface readback_buffer_if;
  import readback_buffer_pkg::*;

  logic                 in_wr;
  logic [RB_WORD_W-1:0] in_data;
  logic                 in_rdy;
  logic                 out_wr;
  logic [RB_WORD_W-1:0] out_data;
  logic                 out_rdy;

  modport master (output in_wr, in_data, out_rdy, input in_rdy, out_wr, out_data);
  modport slave  (input in_wr, in_data, out_rdy, output in_rdy, out_wr, out_data);
endinterface

// File: rtl/fifo_sync.sv
// Generic synchronous FIFO with registered first-word-fall-through head; 1-cycle write-to-head latency.
// Writes ignored while full; head holds steady until rd while rd_vld; level counts head plus RAM words.
module fifo_sync #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_vld,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int                    DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LVL_MAX = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   ram_cnt;
  logic                  push;
  logic                  pop;
  logic                  load;

  assign full    = (level == LVL_MAX);
  assign empty   = (level == '0);
  assign push    = wr & ~full;
  assign pop     = rd & rd_vld;
  assign ram_cnt = level - (rd_vld ? LVL_ONE : '0);
  // Refill the head whenever it is free or being consumed; words written this edge wait one cycle.
  assign load    = (ram_cnt != '0) & (~rd_vld | pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
      rd_vld  <= 1'b0;
      level   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (load) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + PTR_ONE;
        rd_vld  <= 1'b1;
      end else if (pop) begin
        rd_vld  <= 1'b0;
      end
      if (push & ~pop)      level <= level + LVL_ONE;
      else if (~push & pop) level <= level - LVL_ONE;
    end
  end

endmodule

// File: rtl/readback_buffer.sv
// Buffers arbiter readback words for the SPI drain, counts overflow drops and injects a channel-F delta report.
// Head appears one cycle after a push to empty; in_rdy low when full, excess words dropped and counted.
module readback_buffer
  import readback_buffer_pkg::*;
#(
  parameter int DEPTH_LOG2   = 4,
  parameter int URGENT_LEVEL = 12
) (
  input  logic                clk,
  input  logic                rst,
  readback_buffer_if.slave    bus,
  output logic [DEPTH_LOG2:0] level,
  output logic                urgent,
  output logic [15:0]         drop_cnt
);

  localparam logic [DEPTH_LOG2:0] URGENT_L = (DEPTH_LOG2+1)'(URGENT_LEVEL);
  localparam logic [DEPTH_LOG2:0] LVL_ONE  = 1;

  inj_state_t           state;
  logic [15:0]          delta_cnt;
  logic                 full;
  logic                 empty;
  logic                 fifo_vld;
  logic                 fifo_rd;
  logic                 fifo_wr;
  logic [RB_WORD_W-1:0] fifo_wdata;
  logic                 drop;
  logic                 push_real;
  logic                 inject;
  logic                 pop;
  logic [DEPTH_LOG2:0]  level_nxt;

  // full is registered state, so a same-cycle pop never rescues a push into a full FIFO.
  assign drop       = bus.in_wr & full;
  assign push_real  = bus.in_wr & ~full;
  assign inject     = (state == ST_PENDING) & ~full & ~bus.in_wr;
  assign fifo_wr    = push_real | inject;
  assign fifo_wdata = inject ? report_word(delta_cnt) : bus.in_data;
  assign fifo_rd    = bus.out_rdy & ~empty;
  assign pop        = fifo_rd & fifo_vld;

  assign bus.in_rdy = ~full;
  assign bus.out_wr = fifo_vld;

  always_comb begin
    level_nxt = level;
    if (fifo_wr & ~pop)      level_nxt = level + LVL_ONE;
    else if (~fifo_wr & pop) level_nxt = level - LVL_ONE;
  end

  fifo_sync #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (RB_WORD_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr      (fifo_wr),
    .wr_data (fifo_wdata),
    .rd      (fifo_rd),
    .rd_data (bus.out_data),
    .rd_vld  (fifo_vld),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      delta_cnt <= '0;
      drop_cnt  <= '0;
      urgent    <= 1'b0;
    end else begin
      urgent <= (level_nxt >= URGENT_L);
      case (state)
        ST_IDLE: begin
          if (drop) begin
            drop_cnt  <= sat_inc16(drop_cnt);
            delta_cnt <= sat_inc16(delta_cnt);
            state     <= ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (drop) begin
            drop_cnt  <= sat_inc16(drop_cnt);
            delta_cnt <= sat_inc16(delta_cnt);
          end else if (inject) begin
            delta_cnt <= '0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_readback_buffer.sv
// Directed self-checking bench for readback_buffer: vector table for streaming, hand sequences for overflow/report/reset.
module tb_readback_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  level;
  logic        urgent;
  logic [15:0] drop_cnt;
  int          checks = 0;
  int          errors = 0;

  readback_buffer_if bus();

  readback_buffer #(.DEPTH_LOG2(4), .URGENT_LEVEL(12)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .level    (level),
    .urgent   (urgent),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        in_wr;
    logic [31:0] in_data;
    logic        out_rdy;
    logic        exp_out_wr;
    logic [31:0] exp_out_data;
    logic [4:0]  exp_level;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] fw(input int i);
    return {4'(i), 28'h0ABC000 + 28'(i)};
  endfunction

  task automatic fill16();
    bus.out_rdy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.in_wr   = 1'b1;
      bus.in_data = fw(i);
      step();
      check("fill_level", 32'(level), 32'(i + 1));
      check("fill_urgent", 32'(urgent), 32'((i + 1) >= 12));
    end
    bus.in_wr = 1'b0;
    check("fill_in_rdy", 32'(bus.in_rdy), 32'd0);
    check("fill_head", bus.out_data, fw(0));
  endtask

  task automatic pop_check(input logic [31:0] exp);
    bus.in_wr   = 1'b0;
    bus.out_rdy = 1'b1;
    check("drain_out_wr", 32'(bus.out_wr), 32'd1);
    check("drain_data", bus.out_data, exp);
    step();
    bus.out_rdy = 1'b0;
  endtask

  initial begin
    bus.in_wr   = 1'b0;
    bus.in_data = '0;
    bus.out_rdy = 1'b0;

    vecs[0] = '{1'b1, 32'h1000_0001, 1'b1, 1'b0, 32'h0,         5'd1};
    vecs[1] = '{1'b1, 32'h2000_0002, 1'b1, 1'b1, 32'h1000_0001, 5'd2};
    vecs[2] = '{1'b1, 32'h3000_0003, 1'b1, 1'b1, 32'h2000_0002, 5'd2};
    vecs[3] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h3000_0003, 5'd1};
    vecs[4] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         5'd0};
    vecs[5] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         5'd0};

    // Reset state
    repeat (2) step();
    check("rst_in_rdy", 32'(bus.in_rdy), 32'd1);
    check("rst_out_wr", 32'(bus.out_wr), 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_urgent", 32'(urgent), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    rst = 1'b0;
    step();

    // Streaming three words through
    for (int i = 0; i < 6; i++) begin
      bus.in_wr   = vecs[i].in_wr;
      bus.in_data = vecs[i].in_data;
      bus.out_rdy = vecs[i].out_rdy;
      step();
      check("vec_out_wr", 32'(bus.out_wr), 32'(vecs[i].exp_out_wr));
      check("vec_level", 32'(level), 32'(vecs[i].exp_level));
      check("vec_urgent", 32'(urgent), 32'd0);
      if (vecs[i].exp_out_wr) check("vec_out_data", bus.out_data, vecs[i].exp_out_data);
    end

    // Fill, overflow by three, then make one slot for the report
    fill16();
    for (int i = 0; i < 3; i++) begin
      bus.in_wr   = 1'b1;
      bus.in_data = 32'hDEAD_0000 + 32'(i);
      step();
    end
    bus.in_wr = 1'b0;
    check("ovf_drop_cnt", 32'(drop_cnt), 32'd3);
    check("ovf_level", 32'(level), 32'd16);
    check("ovf_head", bus.out_data, fw(0));
    bus.out_rdy = 1'b1;
    step();
    bus.out_rdy = 1'b0;
    check("pop1_level", 32'(level), 32'd15);
    check("pop1_head", bus.out_data, fw(1));
    step();
    check("inject_level", 32'(level), 32'd16);
    check("inject_drop_cnt", 32'(drop_cnt), 32'd3);
    for (int i = 1; i < 16; i++) pop_check(fw(i));
    pop_check(32'hF000_0003);
    check("drain_level", 32'(level), 32'd0);
    repeat (3) step();
    check("no_second_report", 32'(bus.out_wr), 32'd0);
    check("idle_drop_cnt", 32'(drop_cnt), 32'd3);

    // Push and pop together while full
    fill16();
    bus.in_wr   = 1'b1;
    bus.in_data = 32'hBEEF_0001;
    bus.out_rdy = 1'b1;
    step();
    bus.in_wr   = 1'b0;
    bus.out_rdy = 1'b0;
    check("pp_level", 32'(level), 32'd15);
    check("pp_drop_cnt", 32'(drop_cnt), 32'd4);
    check("pp_head", bus.out_data, fw(1));
    step();
    check("pp_inject_level", 32'(level), 32'd16);
    for (int i = 1; i < 16; i++) pop_check(fw(i));
    pop_check(32'hF000_0001);
    check("pp_drain_level", 32'(level), 32'd0);

    // Counter saturation
    fill16();
    bus.in_wr   = 1'b1;
    bus.in_data = 32'hCAFE_0000;
    repeat (70000) step();
    bus.in_wr = 1'b0;
    check("sat_drop_cnt", 32'(drop_cnt), 32'h0000_FFFF);
    check("sat_level", 32'(level), 32'd16);
    for (int i = 0; i < 16; i++) pop_check(fw(i));
    pop_check(32'hF000_FFFF);
    check("sat_drain_level", 32'(level), 32'd0);

    // Asynchronous reset mid-burst with a report pending
    fill16();
    bus.in_wr   = 1'b1;
    bus.in_data = 32'h5555_0000;
    repeat (2) step();
    #3;
    rst = 1'b1;
    #1;
    check("arst_out_wr", 32'(bus.out_wr), 32'd0);
    check("arst_level", 32'(level), 32'd0);
    check("arst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("arst_in_rdy", 32'(bus.in_rdy), 32'd1);
    check("arst_urgent", 32'(urgent), 32'd0);
    check("arst_out_data", bus.out_data, 32'd0);
    bus.in_wr = 1'b0;
    step();
    rst = 1'b0;
    repeat (5) step();
    check("post_rst_no_report", 32'(bus.out_wr), 32'd0);
    check("post_rst_level", 32'(level), 32'd0);
    bus.in_wr   = 1'b1;
    bus.in_data = 32'h7000_0007;
    step();
    bus.in_wr = 1'b0;
    step();
    check("post_rst_out_wr", 32'(bus.out_wr), 32'd1);
    check("post_rst_data", bus.out_data, 32'h7000_0007);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
